// File: rtl/hnf_txrsp.sv
// HN-F TXRSP link transmitter: response queue, L-credit accounting,
// TX link-activation FSM and LCrdReturn generation on deactivation.

package hnf_txrsp_pkg;
    typedef struct packed {
        logic [3:0] qos;
        logic [6:0] tgtid;
        logic [6:0] srcid;
        logic [7:0] txnid;
        logic [4:0] opcode;
        logic [1:0] resperr;
        logic [2:0] resp;
        logic [7:0] dbid;
    } rspflit_t;

    localparam int RSPFLIT_W = $bits(rspflit_t);
endpackage

module hnf_txrsp
    import hnf_txrsp_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_LCRD    = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [RSPFLIT_W-1:0] i_txrsp_in,
    input  logic                 i_txrsp_in_valid,
    output logic                 o_txrsp_in_ready,
    input  logic                 i_link_active_req,
    output logic                 o_txlinkactivereq,
    input  logic                 i_txlinkactiveack,
    output logic [RSPFLIT_W-1:0] o_txrspflit,
    output logic                 o_txrspflitv,
    output logic                 o_txrspflitpend,
    input  logic                 i_txrsplcrdv,
    output logic [3:0]           o_lcrd_count,
    output logic                 o_lcrd_overflow
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_STOP       = 2'd0,
        ST_ACTIVATE   = 2'd1,
        ST_RUN        = 2'd2,
        ST_DEACTIVATE = 2'd3
    } link_state_t;

    link_state_t r_state;
    link_state_t w_state_next;

    // Response queue storage and bookkeeping
    logic [RSPFLIT_W-1:0] r_mem [QUEUE_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_q_count;

    // Output and credit registers
    logic [RSPFLIT_W-1:0] r_flit;
    logic                 r_flitv;
    logic                 r_linkreq;
    logic                 r_pend;
    logic [3:0]           r_lcrd_count;
    logic                 r_lcrd_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_has_credit;
    logic w_send_data;
    logic w_send_ret;
    logic w_send;
    logic w_lcrd_in;

    assign w_full       = (r_q_count == (AW + 1)'(QUEUE_DEPTH));
    assign w_empty      = (r_q_count == '0);
    assign w_has_credit = (r_lcrd_count != 4'd0);

    // Queue only accepts while the link is up and still requested
    assign o_txrsp_in_ready = (r_state == ST_RUN) && i_link_active_req && !w_full;
    assign w_push           = i_txrsp_in_valid && o_txrsp_in_ready;

    assign w_send_data = (r_state == ST_RUN) && !w_empty && w_has_credit;
    assign w_send_ret  = (r_state == ST_DEACTIVATE) && w_has_credit;
    assign w_send      = w_send_data || w_send_ret;

    // Credits granted while the link is stopped are not ours to hold
    assign w_lcrd_in = i_txrsplcrdv && (r_state != ST_STOP);

    // Link state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Link next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STOP: begin
                if (i_link_active_req && !i_txlinkactiveack) begin
                    w_state_next = ST_ACTIVATE;
                end
            end
            ST_ACTIVATE: begin
                if (i_txlinkactiveack) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_link_active_req && w_empty && !w_send_data) begin
                    w_state_next = ST_DEACTIVATE;
                end
            end
            ST_DEACTIVATE: begin
                if (!w_has_credit && !w_lcrd_in && !i_txlinkactiveack) begin
                    w_state_next = ST_STOP;
                end
            end
            default: w_state_next = ST_STOP;
        endcase
    end

    // Link request and pend are registered copies of the next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_linkreq <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_linkreq <= (w_state_next == ST_ACTIVATE) || (w_state_next == ST_RUN);
            r_pend    <= (w_state_next == ST_RUN) || (w_state_next == ST_DEACTIVATE);
        end
    end

    // Queue storage write; contents need no reset since the pointers gate them
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_txrsp_in;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_send_data) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_send_data})
                2'b10:   r_q_count <= r_q_count + 1'b1;
                2'b01:   r_q_count <= r_q_count - 1'b1;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    // Outgoing flit register; holds last flit while idle, LCrdReturn is all-zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flit  <= '0;
            r_flitv <= 1'b0;
        end else begin
            r_flitv <= w_send;
            if (w_send_data) begin
                r_flit <= r_mem[r_rd_ptr];
            end else if (w_send_ret) begin
                r_flit <= '0;
            end
        end
    end

    // L-credit counter with saturation and sticky overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lcrd_count    <= 4'd0;
            r_lcrd_overflow <= 1'b0;
        end else begin
            if (w_lcrd_in && !w_send) begin
                if (r_lcrd_count == 4'(MAX_LCRD)) begin
                    r_lcrd_overflow <= 1'b1;
                end else begin
                    r_lcrd_count <= r_lcrd_count + 4'd1;
                end
            end else if (w_send && !w_lcrd_in) begin
                r_lcrd_count <= r_lcrd_count - 4'd1;
            end
        end
    end

    assign o_txlinkactivereq = r_linkreq;
    assign o_txrspflitpend   = r_pend;
    assign o_txrspflit       = r_flit;
    assign o_txrspflitv      = r_flitv;
    assign o_lcrd_count      = r_lcrd_count;
    assign o_lcrd_overflow   = r_lcrd_overflow;

endmodule

// File: tb/tb_hnf_txrsp.sv
// Directed bench for hnf_txrsp: bring-up, credit gating, back-to-back
// sends, full-queue stall, deactivation credit return, overflow and reset.

module tb_hnf_txrsp;
    import hnf_txrsp_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [RSPFLIT_W-1:0] txrsp_in;
    logic                 txrsp_in_valid;
    logic                 txrsp_in_ready;
    logic                 link_active_req;
    logic                 txlinkactivereq;
    logic                 txlinkactiveack;
    logic [RSPFLIT_W-1:0] txrspflit;
    logic                 txrspflitv;
    logic                 txrspflitpend;
    logic                 txrsplcrdv;
    logic [3:0]           lcrd_count;
    logic                 lcrd_overflow;

    int checks = 0;
    int errors = 0;

    rspflit_t f [13];
    rspflit_t obs_flit;

    hnf_txrsp #(.QUEUE_DEPTH(4), .MAX_LCRD(15)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_txrsp_in        (txrsp_in),
        .i_txrsp_in_valid  (txrsp_in_valid),
        .o_txrsp_in_ready  (txrsp_in_ready),
        .i_link_active_req (link_active_req),
        .o_txlinkactivereq (txlinkactivereq),
        .i_txlinkactiveack (txlinkactiveack),
        .o_txrspflit       (txrspflit),
        .o_txrspflitv      (txrspflitv),
        .o_txrspflitpend   (txrspflitpend),
        .i_txrsplcrdv      (txrsplcrdv),
        .o_lcrd_count      (lcrd_count),
        .o_lcrd_overflow   (lcrd_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flit(input string tag, input rspflit_t exp);
        chk({tag, "_v"}, 64'(txrspflitv), 64'd1);
        chk({tag, "_flit"}, 64'(txrspflit), 64'(exp));
        $display("flit %s: v=%0b data=%0h", tag, txrspflitv, txrspflit);
    endtask

    initial begin
        for (int i = 0; i < 13; i++) begin
            f[i] = '0;
            f[i].qos    = 4'(i + 1);
            f[i].tgtid  = 7'(8'h10 + i);
            f[i].srcid  = 7'(8'h20 + i);
            f[i].txnid  = 8'(8'hA0 + i);
            f[i].opcode = 5'(i + 1);
            f[i].resp   = 3'(i);
            f[i].dbid   = 8'(8'h50 + i);
        end

        rst_n = 1'b0;
        txrsp_in = '0;
        txrsp_in_valid = 1'b0;
        link_active_req = 1'b0;
        txlinkactiveack = 1'b0;
        txrsplcrdv = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_flitv", 64'(txrspflitv), 64'd0);
        chk("rst_pend", 64'(txrspflitpend), 64'd0);
        chk("rst_linkreq", 64'(txlinkactivereq), 64'd0);
        chk("rst_flit", 64'(txrspflit), 64'd0);
        chk("rst_ready", 64'(txrsp_in_ready), 64'd0);
        chk("rst_lcrd", 64'(lcrd_count), 64'd0);
        chk("rst_ovf", 64'(lcrd_overflow), 64'd0);
        $display("reset: outputs checked");
        rst_n = 1'b1;
        step();

        // Bring-up: ACK two cycles after REQ
        link_active_req = 1'b1;
        step();
        chk("up_linkreq", 64'(txlinkactivereq), 64'd1);
        chk("up_ready_act", 64'(txrsp_in_ready), 64'd0);
        step();
        step();
        txlinkactiveack = 1'b1;
        step();
        chk("up_pend", 64'(txrspflitpend), 64'd1);
        chk("up_ready", 64'(txrsp_in_ready), 64'd1);
        $display("bring-up: RUN, pend=%0b ready=%0b", txrspflitpend, txrsp_in_ready);

        // Credit gating: three pushes with no credit
        for (int i = 0; i < 3; i++) begin
            txrsp_in = f[i];
            txrsp_in_valid = 1'b1;
            step();
            chk("gate_nov", 64'(txrspflitv), 64'd0);
            $display("push f%0d: flitv=%0b", i, txrspflitv);
        end
        txrsp_in_valid = 1'b0;
        step();
        chk("gate_nov_idle", 64'(txrspflitv), 64'd0);

        txrsplcrdv = 1'b1;
        step();
        chk("gate_lcrd1", 64'(lcrd_count), 64'd1);
        chk("gate_nov_c1", 64'(txrspflitv), 64'd0);
        step();
        txrsplcrdv = 1'b0;
        chk_flit("gate_f0", f[0]);
        chk("gate_lcrd_sim", 64'(lcrd_count), 64'd1);
        step();
        chk_flit("gate_f1", f[1]);
        chk("gate_lcrd0", 64'(lcrd_count), 64'd0);
        step();
        chk("gate_stop", 64'(txrspflitv), 64'd0);
        chk("gate_hold", 64'(txrspflit), 64'(f[1]));

        // Drain remaining f2 with one credit
        txrsplcrdv = 1'b1;
        step();
        txrsplcrdv = 1'b0;
        chk("drain_nov", 64'(txrspflitv), 64'd0);
        step();
        chk_flit("drain_f2", f[2]);
        step();
        chk("drain_idle", 64'(txrspflitv), 64'd0);

        // Back-to-back: four credits, four consecutive pushes
        txrsplcrdv = 1'b1;
        for (int i = 0; i < 4; i++) step();
        txrsplcrdv = 1'b0;
        chk("b2b_lcrd4", 64'(lcrd_count), 64'd4);
        chk("b2b_nov", 64'(txrspflitv), 64'd0);
        txrsp_in_valid = 1'b1;
        txrsp_in = f[3];
        step();
        chk("b2b_lat1", 64'(txrspflitv), 64'd0);
        txrsp_in = f[4];
        step();
        chk_flit("b2b_f3", f[3]);
        txrsp_in = f[5];
        step();
        chk_flit("b2b_f4", f[4]);
        txrsp_in = f[6];
        step();
        chk_flit("b2b_f5", f[5]);
        txrsp_in_valid = 1'b0;
        step();
        chk_flit("b2b_f6", f[6]);
        chk("b2b_lcrd0", 64'(lcrd_count), 64'd0);
        step();
        chk("b2b_end", 64'(txrspflitv), 64'd0);

        // Fill queue with no credit; fifth push must stall
        txrsp_in_valid = 1'b1;
        for (int i = 7; i < 11; i++) begin
            txrsp_in = f[i];
            chk("full_ready_pre", 64'(txrsp_in_ready), 64'd1);
            step();
        end
        chk("full_ready", 64'(txrsp_in_ready), 64'd0);
        txrsp_in = f[11];
        step();
        chk("full_stall", 64'(txrsp_in_ready), 64'd0);
        chk("full_nov", 64'(txrspflitv), 64'd0);
        $display("full: ready=%0b", txrsp_in_ready);
        txrsp_in_valid = 1'b0;

        // Simultaneous credit and send at count 1
        txrsplcrdv = 1'b1;
        step();
        chk("sim_lcrd1", 64'(lcrd_count), 64'd1);
        step();
        txrsplcrdv = 1'b0;
        chk_flit("sim_f7", f[7]);
        chk("sim_lcrd_hold", 64'(lcrd_count), 64'd1);
        chk("sim_ready", 64'(txrsp_in_ready), 64'd1);
        step();
        chk_flit("sim_f8", f[8]);
        txrsplcrdv = 1'b1;
        step();
        step();
        txrsplcrdv = 1'b0;
        chk_flit("sim_f9", f[9]);
        step();
        chk_flit("sim_f10", f[10]);
        chk("sim_lcrd0", 64'(lcrd_count), 64'd0);

        // Three credits with empty queue: nothing (not even the stalled f11) goes out
        txrsplcrdv = 1'b1;
        for (int i = 0; i < 3; i++) step();
        txrsplcrdv = 1'b0;
        step();
        chk("deact_lcrd3", 64'(lcrd_count), 64'd3);
        chk("deact_nov", 64'(txrspflitv), 64'd0);

        // Deactivate: credits returned as LCrdReturn flits
        link_active_req = 1'b0;
        step();
        chk("deact_linkreq", 64'(txlinkactivereq), 64'd0);
        chk("deact_pend", 64'(txrspflitpend), 64'd1);
        chk("deact_ready", 64'(txrsp_in_ready), 64'd0);
        chk("deact_nov0", 64'(txrspflitv), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            obs_flit = rspflit_t'(txrspflit);
            chk_flit("lcrdret", '0);
            chk("lcrdret_opc", 64'(obs_flit.opcode), 64'd0);
            chk("lcrdret_cnt", 64'(lcrd_count), 64'(2 - i));
        end
        step();
        chk("deact_done", 64'(txrspflitv), 64'd0);
        chk("deact_wait_ack", 64'(txrspflitpend), 64'd1);
        txlinkactiveack = 1'b0;
        step();
        chk("stop_pend", 64'(txrspflitpend), 64'd0);
        chk("stop_linkreq", 64'(txlinkactivereq), 64'd0);
        $display("deactivate: STOP, lcrd=%0d", lcrd_count);

        // Credit in STOP is ignored
        txrsplcrdv = 1'b1;
        step();
        chk("stop_ign", 64'(lcrd_count), 64'd0);

        // Overflow: credits while in ACTIVATE with ACK held low
        link_active_req = 1'b1;
        step();
        chk("ovf_act", 64'(txlinkactivereq), 64'd1);
        chk("ovf_cnt0", 64'(lcrd_count), 64'd0);
        for (int i = 0; i < 15; i++) step();
        chk("ovf_cnt15", 64'(lcrd_count), 64'd15);
        chk("ovf_pre", 64'(lcrd_overflow), 64'd0);
        step();
        txrsplcrdv = 1'b0;
        chk("ovf_sat", 64'(lcrd_count), 64'd15);
        chk("ovf_set", 64'(lcrd_overflow), 64'd1);
        $display("overflow: lcrd=%0d ovf=%0b", lcrd_count, lcrd_overflow);

        // Reset mid-send
        txlinkactiveack = 1'b1;
        step();
        txrsp_in = f[12];
        txrsp_in_valid = 1'b1;
        step();
        txrsp_in_valid = 1'b0;
        step();
        chk_flit("mid_f12", f[12]);
        chk("mid_ovf_sticky", 64'(lcrd_overflow), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_flitv", 64'(txrspflitv), 64'd0);
        chk("arst_flit", 64'(txrspflit), 64'd0);
        chk("arst_linkreq", 64'(txlinkactivereq), 64'd0);
        chk("arst_pend", 64'(txrspflitpend), 64'd0);
        chk("arst_ready", 64'(txrsp_in_ready), 64'd0);
        chk("arst_lcrd", 64'(lcrd_count), 64'd0);
        chk("arst_ovf", 64'(lcrd_overflow), 64'd0);
        $display("async reset: outputs checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
